// File: rtl/edgedetect_multi.sv
// edgedetect_multi: per-channel synchronizer, debounce filter, edge pulses and sticky W1C event flags
//   iCLK, iRST_N          clock (rising edge), asynchronous active-low reset
//   iSIG                  raw channel inputs
//   iRISE_EN / iFALL_EN   per-channel enables for setting oEVT on rising / falling edges
//   iCLR                  write-1-to-clear strobe for oEVT
//   oLEVEL                filtered, synchronized level
//   oRE / oFE / oRFE      one-cycle rising / falling / either edge pulses
//   oEVT, oIRQ            sticky event flags and their OR
module edgedetect_multi #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CNT  = 4
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [WIDTH-1:0] iSIG,
  input  logic [WIDTH-1:0] iRISE_EN,
  input  logic [WIDTH-1:0] iFALL_EN,
  input  logic [WIDTH-1:0] iCLR,
  output logic [WIDTH-1:0] oLEVEL,
  output logic [WIDTH-1:0] oRE,
  output logic [WIDTH-1:0] oFE,
  output logic [WIDTH-1:0] oRFE,
  output logic [WIDTH-1:0] oEVT,
  output logic             oIRQ
);
  localparam int CW = FILTER_CNT > 1 ? $clog2(FILTER_CNT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(FILTER_CNT - 1);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] set;
  logic [CW-1:0]    cnt [WIDTH];
  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s = iSIG;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) sync <= '0;
        else begin
          sync[0] <= iSIG;
          for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
        end
      end
      assign s = sync[SYNC_STAGES-1];
    end
  endgenerate
  // a channel accepts its new level once the mismatch has survived FILTER_CNT edges
  always_comb begin
    acc = '0;
    for (int j = 0; j < WIDTH; j++) acc[j] = (s[j] != oLEVEL[j]) && (cnt[j] == CMAX);
  end
  assign set  = (oRE & iRISE_EN) | (oFE & iFALL_EN);
  assign oRFE = oRE | oFE;
  assign oIRQ = |oEVT;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oLEVEL <= '0;
      oRE    <= '0;
      oFE    <= '0;
      oEVT   <= '0;
      for (int j = 0; j < WIDTH; j++) cnt[j] <= '0;
    end else begin
      oLEVEL <= oLEVEL ^ acc;
      oRE    <= acc & s;
      oFE    <= acc & ~s;
      oEVT   <= set | (~iCLR & oEVT);
      for (int j = 0; j < WIDTH; j++) cnt[j] <= (s[j] == oLEVEL[j] || acc[j]) ? '0 : cnt[j] + 1'b1;
    end
  end
endmodule
